// File: rtl/pc_predict_unit.sv
// ---------------------------------------------------------------------------
// pc_predict_unit
//   Fetch-stage PC generator with stall hold, execute-stage redirect and a
//   direct-mapped branch target buffer (BTB).
//
//   The fetch PC predicts its successor from the BTB. The EX stage resolves
//   the branch/JAL/JALR in flight, corrects the PC when the prediction was
//   wrong and raises Mispredict so IF/ID can be flushed.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   Stall        in   hold the fetch PC
//   BranchE      in   EX holds a valid branch/JAL/JALR
//   PCSrc        in   EX control transfer taken
//   JALROn       in   EX instruction is JALR
//   ImmOp        in   EX immediate
//   rs1          in   EX rs1 operand
//   PCE          in   PC of the EX instruction
//   PredTakenE   in   prediction carried down the pipe with that instruction
//   PredTargetE  in   predicted target carried down the pipe
//   PC           out  current fetch PC
//   PCPlus4      out  PC + 4
//   PredTaken    out  BTB hit for PC
//   PredTarget   out  BTB target for PC (0 on miss)
//   Mispredict   out  redirect / flush request (combinational)
//   MisalignErr  out  redirect target not 4-byte aligned
// ---------------------------------------------------------------------------
module pc_predict_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            BranchE,
    input  logic            PCSrc,
    input  logic            JALROn,
    input  logic [XLEN-1:0] ImmOp,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] PCE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            PredTaken,
    output logic [XLEN-1:0] PredTarget,
    output logic            Mispredict,
    output logic            MisalignErr
);

    localparam int              IDX  = $clog2(BTB_ENTRIES);
    localparam int              TAGW = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAGW-1:0]        btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]  fetch_idx;
    logic [TAGW-1:0] fetch_tag;

    // Execute-side resolution
    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target_e;
    logic [XLEN-1:0] actual_e;
    logic            ex_hit;

    assign fetch_idx = pc_q[IDX+1:2];
    assign fetch_tag = pc_q[XLEN-1:IDX+2];
    assign ex_idx    = PCE[IDX+1:2];
    assign ex_tag    = PCE[XLEN-1:IDX+2];

    // Lookup reads the registered array only, so an update in the same
    // cycle becomes visible on the following cycle.
    assign PredTaken  = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
    assign PredTarget = PredTaken ? btb_target_q[fetch_idx] : '0;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + FOUR;

    // JALR clears bit 0 of the computed address; bit 1 is left for the
    // misalignment check.
    assign jalr_sum = rs1 + ImmOp;
    assign target_e = JALROn ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmOp);
    assign actual_e = PCSrc ? target_e : (PCE + FOUR);

    // A taken prediction is only correct if its target also matches.
    assign Mispredict  = BranchE && ((PCSrc != PredTakenE) ||
                                     (PCSrc && PredTakenE && (PredTargetE != target_e)));
    assign MisalignErr = Mispredict && PCSrc && target_e[1];

    assign ex_hit = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);

    always_comb begin
        pc_d = pc_q + FOUR;
        if (Mispredict) begin
            pc_d = actual_e;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (PredTaken) begin
            pc_d = PredTarget;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB training follows EX resolution and ignores Stall: a taken transfer
    // (re)allocates its entry, a not-taken one drops only its own entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (BranchE) begin
            if (PCSrc) begin
                btb_valid_q[ex_idx]  <= 1'b1;
                btb_tag_q[ex_idx]    <= ex_tag;
                btb_target_q[ex_idx] <= target_e;
            end else if (ex_hit) begin
                btb_valid_q[ex_idx]  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        BranchE;
    logic        PCSrc;
    logic        JALROn;
    logic [31:0] ImmOp;
    logic [31:0] rs1;
    logic [31:0] PCE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        Mispredict;
    logic        MisalignErr;

    int errors = 0;
    int checks = 0;

    // Expected fetch PC values, pushed when the stimulus is driven and
    // popped once the clock edge has produced them.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    pc_predict_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Stall(Stall),
        .BranchE(BranchE),
        .PCSrc(PCSrc),
        .JALROn(JALROn),
        .ImmOp(ImmOp),
        .rs1(rs1),
        .PCE(PCE),
        .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE),
        .PC(PC),
        .PCPlus4(PCPlus4),
        .PredTaken(PredTaken),
        .PredTarget(PredTarget),
        .Mispredict(Mispredict),
        .MisalignErr(MisalignErr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        BranchE     = 1'b0;
        PCSrc       = 1'b0;
        JALROn      = 1'b0;
        PredTakenE  = 1'b0;
        PredTargetE = '0;
        ImmOp       = '0;
        rs1         = '0;
        PCE         = '0;
    endtask

    task automatic drive_ex(input logic src, input logic jalr, input logic pt,
                            input logic [31:0] ptgt, input logic [31:0] imm,
                            input logic [31:0] r1, input logic [31:0] pce);
        BranchE     = 1'b1;
        PCSrc       = src;
        JALROn      = jalr;
        PredTakenE  = pt;
        PredTargetE = ptgt;
        ImmOp       = imm;
        rs1         = r1;
        PCE         = pce;
    endtask

    // Not-taken resolution of a predicted-taken instruction at addr-4:
    // forces a redirect to addr without allocating a BTB entry.
    task automatic redirect_to(input logic [31:0] addr);
        drive_ex(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, addr - 32'h4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b0;
        Stall = 1'b0;
        clear_ex();
        #2;
        checks++;
        if (PC !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0);
        end
        checks++;
        if (PCPlus4 !== 32'h4) begin
            errors++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4, 32'h4);
        end
        checks++;
        if (PredTaken !== 1'b0 || PredTarget !== 32'h0) begin
            errors++; $display("FAIL reset_pred: got %b/%h want 0/0", PredTaken, PredTarget);
        end
        tick();
        tick();
        checks++;
        if (PC !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got %h want %h", PC, 32'h0);
        end
        #4 rst = 1'b1;
    endtask

    task automatic test_sequential();
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (PC !== exp_pc || PredTaken !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got %h/%b want %h/0", i, PC, PredTaken, exp_pc);
            end
        end
    endtask

    task automatic test_btb_train();
        drive_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 32'h10);
        exp_q.push_back(32'h30);
        #1;
        checks++;
        if (Mispredict !== 1'b1 || MisalignErr !== 1'b0) begin
            errors++; $display("FAIL train_mispredict: got %b/%b want 1/0", Mispredict, MisalignErr);
        end
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL train_redirect: got %h want %h", PC, exp_pc);
        end
        redirect_to(32'h10);
        exp_q.push_back(32'h10);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        #1;
        checks++;
        if (PC !== exp_pc || PredTaken !== 1'b1 || PredTarget !== 32'h30) begin
            errors++;
            $display("FAIL train_hit: got %h/%b/%h want %h/1/00000030", PC, PredTaken, PredTarget, exp_pc);
        end
        // Correct taken prediction: no redirect. Wrong target: redirect.
        drive_ex(1'b1, 1'b0, 1'b1, 32'h30, 32'h20, 32'h0, 32'h10);
        #1;
        checks++;
        if (Mispredict !== 1'b0) begin
            errors++; $display("FAIL correct_pred: got %b want 0", Mispredict);
        end
        PredTargetE = 32'h40;
        #1;
        checks++;
        if (Mispredict !== 1'b1) begin
            errors++; $display("FAIL wrong_target: got %b want 1", Mispredict);
        end
        clear_ex();
        exp_q.push_back(32'h30);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL predicted_next: got %h want %h", PC, exp_pc);
        end
    endtask

    task automatic test_btb_invalidate();
        drive_ex(1'b0, 1'b0, 1'b1, 32'h30, 32'h20, 32'h0, 32'h10);
        exp_q.push_back(32'h14);
        #1;
        checks++;
        if (Mispredict !== 1'b1) begin
            errors++; $display("FAIL inval_mispredict: got %b want 1", Mispredict);
        end
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL inval_redirect: got %h want %h", PC, exp_pc);
        end
        redirect_to(32'h10);
        exp_q.push_back(32'h10);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        #1;
        checks++;
        if (PC !== exp_pc || PredTaken !== 1'b0 || PredTarget !== 32'h0) begin
            errors++;
            $display("FAIL inval_miss: got %h/%b/%h want %h/0/0", PC, PredTaken, PredTarget, exp_pc);
        end
        exp_q.push_back(32'h14);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL inval_next: got %h want %h", PC, exp_pc);
        end
    endtask

    task automatic test_jalr();
        drive_ex(1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h101, 32'h200);
        exp_q.push_back(32'h104);
        #1;
        checks++;
        if (Mispredict !== 1'b1 || MisalignErr !== 1'b0) begin
            errors++; $display("FAIL jalr_aligned: got %b/%b want 1/0", Mispredict, MisalignErr);
        end
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL jalr_pc: got %h want %h", PC, exp_pc);
        end
        drive_ex(1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h103, 32'h204);
        exp_q.push_back(32'h106);
        #1;
        checks++;
        if (MisalignErr !== 1'b1) begin
            errors++; $display("FAIL jalr_misalign: got %b want 1", MisalignErr);
        end
        // Correctly predicted misaligned target raises no error (no redirect).
        PredTakenE  = 1'b1;
        PredTargetE = 32'h106;
        #1;
        checks++;
        if (Mispredict !== 1'b0 || MisalignErr !== 1'b0) begin
            errors++; $display("FAIL jalr_predicted: got %b/%b want 0/0", Mispredict, MisalignErr);
        end
        PredTakenE  = 1'b0;
        PredTargetE = 32'h0;
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL jalr_misalign_pc: got %h want %h", PC, exp_pc);
        end
    endtask

    task automatic test_stall();
        redirect_to(32'h8);
        exp_q.push_back(32'h8);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL stall_setup: got %h want %h", PC, exp_pc);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h8);
            tick();
            exp_pc = exp_q.pop_front();
            checks++;
            if (PC !== exp_pc) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, PC, exp_pc);
            end
        end
        redirect_to(32'h40);
        exp_q.push_back(32'h40);
        tick();
        clear_ex();
        Stall = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL stall_override: got %h want %h", PC, exp_pc);
        end
        exp_q.push_back(32'h44);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL stall_release: got %h want %h", PC, exp_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc || PCPlus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_top: got %h/%h want %h/0", PC, PCPlus4, exp_pc);
        end
        exp_q.push_back(32'h0);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL wrap_zero: got %h want %h", PC, exp_pc);
        end
    endtask

    task automatic test_reset_mid();
        drive_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 32'h10);
        exp_q.push_back(32'h30);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL retrain_pc: got %h want %h", PC, exp_pc);
        end
        // Inputs still request a redirect and a BTB write while reset hits.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (PC !== 32'h0 || PCPlus4 !== 32'h4 || PredTaken !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got %h/%h/%b want 0/4/0", PC, PCPlus4, PredTaken);
        end
        tick();
        checks++;
        if (PC !== 32'h0) begin
            errors++; $display("FAIL midreset_hold: got %h want 0", PC);
        end
        clear_ex();
        #4 rst = 1'b1;
        exp_q.push_back(32'h4);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL midreset_first_edge: got %h want %h", PC, exp_pc);
        end
        redirect_to(32'h10);
        exp_q.push_back(32'h10);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        #1;
        checks++;
        if (PC !== exp_pc || PredTaken !== 1'b0 || PredTarget !== 32'h0) begin
            errors++;
            $display("FAIL midreset_btb_cleared: got %h/%b/%h want %h/0/0", PC, PredTaken, PredTarget, exp_pc);
        end
        // Same-cycle write to the index being looked up is not bypassed.
        drive_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 32'h10);
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++; $display("FAIL no_bypass: got %b want 0", PredTaken);
        end
        exp_q.push_back(32'h30);
        tick();
        clear_ex();
        exp_pc = exp_q.pop_front();
        checks++;
        if (PC !== exp_pc) begin
            errors++; $display("FAIL no_bypass_pc: got %h want %h", PC, exp_pc);
        end
        redirect_to(32'h10);
        tick();
        clear_ex();
        #1;
        checks++;
        if (PredTaken !== 1'b1 || PredTarget !== 32'h30) begin
            errors++; $display("FAIL write_visible: got %b/%h want 1/00000030", PredTaken, PredTarget);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_btb_train();
        test_btb_invalidate();
        test_jalr();
        test_stall();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the sequence is a few hundred ns; stop hard if it stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
